// File: rtl/scale_cache_pingpong.sv
// rtl/scale_cache_pingpong.sv - two-bank ping-pong frame buffer between scaler writer and frame reader
module scale_cache_pingpong #(
  parameter int IMG_W  = 320,
  parameter int IMG_H  = 240,
  parameter int DATA_W = 8,
  parameter int XW     = 9,
  parameter int YW     = 8
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [XW-1:0]     wr_waddrX,
  input  logic [YW-1:0]     wr_waddrY,
  input  logic [DATA_W-1:0] wr_wdata,
  input  logic              wr_we,
  input  logic              wr_frame_done,
  output logic              wr_bank_free,
  input  logic [XW-1:0]     rd_raddrX,
  input  logic [YW-1:0]     rd_raddrY,
  output logic [DATA_W-1:0] rd_q,
  output logic              rd_frame_valid,
  input  logic              rd_release,
  output logic              err_overflow,
  output logic              err_addr
);

  localparam int unsigned FRAME = IMG_W * IMG_H;
  localparam int unsigned DEPTH = 2 * FRAME;
  localparam int          AW    = $clog2(DEPTH);

  // Bank b occupies words [b*FRAME, (b+1)*FRAME); not reset, contents are don't-care until written.
  logic [DATA_W-1:0] mem [DEPTH];

  logic       wb;        // bank the writer is filling
  logic       rb;        // bank the reader is consuming
  logic [1:0] full_cnt;  // completed frames not yet released (0..2)

  logic wr_in_range, rd_in_range;
  logic fd_acc, rel_acc, wr_acc;

  function automatic logic [AW-1:0] lin(input logic bank, input logic [XW-1:0] x,
                                        input logic [YW-1:0] y);
    int unsigned v;
    v = (bank ? FRAME : 32'd0) + 32'(y) * 32'(IMG_W) + 32'(x);
    return AW'(v);
  endfunction

  assign wr_in_range    = (32'(wr_waddrX) < 32'(IMG_W)) && (32'(wr_waddrY) < 32'(IMG_H));
  assign rd_in_range    = (32'(rd_raddrX) < 32'(IMG_W)) && (32'(rd_raddrY) < 32'(IMG_H));
  assign wr_bank_free   = (full_cnt != 2'd2);
  assign rd_frame_valid = (full_cnt != 2'd0);

  // Acceptance is judged on the pre-edge count, so a release cannot rescue a frame_done at full.
  assign fd_acc  = wr_frame_done & wr_bank_free;
  assign rel_acc = rd_release & rd_frame_valid;
  assign wr_acc  = wr_we & wr_bank_free & wr_in_range;

  // Pixel store: a write coinciding with frame_done still lands in the outgoing bank.
  always_ff @(posedge clk) begin
    if (wr_acc) mem[lin(wb, wr_waddrX, wr_waddrY)] <= wr_wdata;
  end

  // Bank pointers, occupancy count and sticky error flags.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wb           <= 1'b0;
      rb           <= 1'b0;
      full_cnt     <= 2'd0;
      err_overflow <= 1'b0;
      err_addr     <= 1'b0;
    end else begin
      if (fd_acc)  wb <= ~wb;
      if (rel_acc) rb <= ~rb;
      if (fd_acc && !rel_acc)      full_cnt <= full_cnt + 2'd1;
      else if (rel_acc && !fd_acc) full_cnt <= full_cnt - 2'd1;
      if ((wr_we || wr_frame_done) && !wr_bank_free) err_overflow <= 1'b1;
      if (wr_we && !wr_in_range)                     err_addr     <= 1'b1;
    end
  end

  // Registered read: uses the bank held before any same-cycle release; zero when nothing readable.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rd_q <= '0;
    end else if (rd_frame_valid && rd_in_range) begin
      rd_q <= mem[lin(rb, rd_raddrX, rd_raddrY)];
    end else begin
      rd_q <= '0;
    end
  end

endmodule

// File: tb/tb_scale_cache_pingpong.sv
// tb/tb_scale_cache_pingpong.sv - randomized self-checking bench with frame-queue reference model
module tb_scale_cache_pingpong;
  localparam int IMG_W = 320;
  localparam int IMG_H = 240;
  localparam int XW    = 9;
  localparam int YW    = 8;
  localparam int FRAME = IMG_W * IMG_H;

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic [XW-1:0] wr_waddrX = '0;
  logic [YW-1:0] wr_waddrY = '0;
  logic [7:0]    wr_wdata = '0;
  logic          wr_we = 1'b0;
  logic          wr_frame_done = 1'b0;
  logic          wr_bank_free;
  logic [XW-1:0] rd_raddrX = '0;
  logic [YW-1:0] rd_raddrY = '0;
  logic [7:0]    rd_q;
  logic          rd_frame_valid;
  logic          rd_release = 1'b0;
  logic          err_overflow;
  logic          err_addr;

  scale_cache_pingpong dut (
    .clk(clk), .resetn(resetn),
    .wr_waddrX(wr_waddrX), .wr_waddrY(wr_waddrY), .wr_wdata(wr_wdata), .wr_we(wr_we),
    .wr_frame_done(wr_frame_done), .wr_bank_free(wr_bank_free),
    .rd_raddrX(rd_raddrX), .rd_raddrY(rd_raddrY), .rd_q(rd_q),
    .rd_frame_valid(rd_frame_valid), .rd_release(rd_release),
    .err_overflow(err_overflow), .err_addr(err_addr)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: a FIFO of completed frame ids (at most two held), pixels keyed by frame id.
  int         frames[$];
  int         wid;
  int         next_id = 0;
  logic [7:0] pix[longint];
  bit         m_ovf, m_addr;
  logic [7:0] m_q;
  bit         m_q_known;
  int         kx[$], ky[$];

  function automatic bit in_rng(int x, int y);
    return (x < IMG_W) && (y < IMG_H);
  endfunction

  task automatic model_reset();
    frames.delete();
    wid = next_id; next_id++;
    m_ovf = 0; m_addr = 0; m_q = 0; m_q_known = 1;
  endtask

  task automatic cycle();
    bit free, valid, nk;
    logic [7:0] nq;
    int rx, ry, wx, wy;
    longint k;
    free = frames.size() < 2;
    valid = frames.size() != 0;
    rx = int'(rd_raddrX); ry = int'(rd_raddrY);
    wx = int'(wr_waddrX); wy = int'(wr_waddrY);
    nq = 8'h00; nk = 1;
    if (valid && in_rng(rx, ry)) begin
      k = longint'(frames[0]) * FRAME + ry * IMG_W + rx;
      if (pix.exists(k)) nq = pix[k];
      else nk = 0;
    end
    if (wr_we && !in_rng(wx, wy)) m_addr = 1;
    if ((wr_we || wr_frame_done) && !free) m_ovf = 1;
    if (wr_we && free && in_rng(wx, wy)) pix[longint'(wid) * FRAME + wy * IMG_W + wx] = wr_wdata;
    if (wr_frame_done && free) begin frames.push_back(wid); wid = next_id; next_id++; end
    if (rd_release && valid) void'(frames.pop_front());
    @(posedge clk); #1;
    m_q = nq; m_q_known = nk;
  endtask

  task automatic write_px(input int x, input int y, input logic [7:0] d, input bit fd);
    wr_waddrX = XW'(x); wr_waddrY = YW'(y); wr_wdata = d; wr_we = 1; wr_frame_done = fd;
    cycle();
    wr_we = 0; wr_frame_done = 0;
  endtask

  task automatic read_px(input int x, input int y);
    rd_raddrX = XW'(x); rd_raddrY = YW'(y);
    cycle();
  endtask

  task automatic pulse(input bit fd, input bit rel);
    wr_frame_done = fd; rd_release = rel;
    cycle();
    wr_frame_done = 0; rd_release = 0;
  endtask

  task automatic test_reset();
    resetn = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++; if (rd_q !== 8'h00) begin errors++; $display("FAIL reset_rd_q got %h want 00", rd_q); end
    resetn = 1;
    cycle();
    checks++; if (wr_bank_free !== 1'b1) begin errors++; $display("FAIL reset_free got %b want 1", wr_bank_free); end
    checks++; if (rd_frame_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", rd_frame_valid); end
    checks++; if ({err_overflow, err_addr} !== 2'b00) begin errors++; $display("FAIL reset_err got %b want 00", {err_overflow, err_addr}); end
    read_px(0, 0);
    checks++; if (rd_q !== 8'h00) begin errors++; $display("FAIL reset_read00 got %h want 00", rd_q); end
  endtask

  task automatic test_frame_write();
    int x, y;
    for (int yy = 0; yy < 10; yy++)
      for (int xx = 0; xx < IMG_W; xx++) write_px(xx, yy, 8'((xx + yy) & 8'hFF), 0);
    write_px(319, 239, 8'((319 + 239) & 8'hFF), 1);
    checks++; if (rd_frame_valid !== 1'b1) begin errors++; $display("FAIL frame1_valid got %b want 1", rd_frame_valid); end
    checks++; if (wr_bank_free !== 1'b1) begin errors++; $display("FAIL frame1_free got %b want 1", wr_bank_free); end
    read_px(5, 7);
    checks++; if (rd_q !== 8'h0C) begin errors++; $display("FAIL read_5_7 got %h want 0c", rd_q); end
    read_px(319, 239);
    checks++; if (rd_q !== 8'h2E) begin errors++; $display("FAIL last_pixel got %h want 2e", rd_q); end
    for (int i = 0; i < 20; i++) begin
      x = $urandom_range(0, IMG_W - 1); y = $urandom_range(0, 9);
      read_px(x, y);
      checks++; if (rd_q !== 8'((x + y) & 8'hFF)) begin errors++; $display("FAIL frame1_rd_%0d_%0d got %h want %h", x, y, rd_q, 8'((x + y) & 8'hFF)); end
    end
  endtask

  task automatic test_overflow();
    int x, y;
    kx.delete(); ky.delete();
    for (int i = 0; i < 150; i++) begin
      x = $urandom_range(0, IMG_W - 1); y = $urandom_range(0, IMG_H - 1);
      kx.push_back(x); ky.push_back(y);
      write_px(x, y, 8'($urandom), 0);
    end
    pulse(1, 0);
    checks++; if (wr_bank_free !== 1'b0) begin errors++; $display("FAIL full_free got %b want 0", wr_bank_free); end
    checks++; if (err_overflow !== 1'b0) begin errors++; $display("FAIL premature_ovf got %b want 0", err_overflow); end
    write_px(1, 1, 8'hAA, 0);
    checks++; if (err_overflow !== 1'b1) begin errors++; $display("FAIL ovf_write got %b want 1", err_overflow); end
    pulse(1, 0);
    checks++; if ({wr_bank_free, rd_frame_valid} !== 2'b01) begin errors++; $display("FAIL ovf_fd_state got %b want 01", {wr_bank_free, rd_frame_valid}); end
    read_px(1, 1);
    checks++; if (rd_q !== 8'h02) begin errors++; $display("FAIL frame1_intact got %h want 02", rd_q); end
    pulse(0, 1);
    checks++; if ({wr_bank_free, rd_frame_valid} !== 2'b11) begin errors++; $display("FAIL rel_state got %b want 11", {wr_bank_free, rd_frame_valid}); end
    for (int i = 0; i < 30; i++) begin
      int j;
      j = $urandom_range(0, kx.size() - 1);
      read_px(kx[j], ky[j]);
      checks++; if (!m_q_known || rd_q !== m_q) begin errors++; $display("FAIL frame2_rd_%0d_%0d got %h want %h", kx[j], ky[j], rd_q, m_q); end
    end
  endtask

  task automatic test_back_to_back();
    int x, y;
    kx.delete(); ky.delete();
    for (int i = 0; i < 80; i++) begin
      x = $urandom_range(0, IMG_W - 1); y = $urandom_range(0, IMG_H - 1);
      kx.push_back(x); ky.push_back(y);
      write_px(x, y, 8'($urandom), 0);
    end
    write_px(2, 3, 8'h5A, 0);
    read_px(2, 3);
    pulse(1, 1);
    checks++; if ({wr_bank_free, rd_frame_valid} !== 2'b11) begin errors++; $display("FAIL swap_state got %b want 11", {wr_bank_free, rd_frame_valid}); end
    read_px(2, 3);
    checks++; if (rd_q !== 8'h5A) begin errors++; $display("FAIL swap_read_2_3 got %h want 5a", rd_q); end
    for (int i = 0; i < 20; i++) begin
      int j;
      j = $urandom_range(0, kx.size() - 1);
      read_px(kx[j], ky[j]);
      checks++; if (!m_q_known || rd_q !== m_q) begin errors++; $display("FAIL frame3_rd_%0d_%0d got %h want %h", kx[j], ky[j], rd_q, m_q); end
    end
  endtask

  task automatic test_addr_range();
    write_px(0, 1, 8'h11, 0);
    write_px(320, 0, 8'h77, 0);
    checks++; if (err_addr !== 1'b1) begin errors++; $display("FAIL err_addr_x got %b want 1", err_addr); end
    write_px(0, 240, 8'h33, 0);
    read_px(320, 0);
    checks++; if (rd_q !== 8'h00) begin errors++; $display("FAIL read_oob got %h want 00", rd_q); end
    checks++; if ({err_overflow, err_addr} !== {m_ovf, m_addr}) begin errors++; $display("FAIL sticky_err got %b want %b", {err_overflow, err_addr}, {m_ovf, m_addr}); end
    pulse(1, 1);
    read_px(0, 1);
    checks++; if (rd_q !== 8'h11) begin errors++; $display("FAIL oob_no_alias got %h want 11", rd_q); end
  endtask

  task automatic test_release_empty();
    pulse(0, 1);
    checks++; if (rd_frame_valid !== 1'b0) begin errors++; $display("FAIL drain_valid got %b want 0", rd_frame_valid); end
    pulse(0, 1);
    checks++; if ({wr_bank_free, rd_frame_valid} !== 2'b10) begin errors++; $display("FAIL empty_rel got %b want 10", {wr_bank_free, rd_frame_valid}); end
    read_px(0, 1);
    checks++; if (rd_q !== 8'h00) begin errors++; $display("FAIL read_invalid got %h want 00", rd_q); end
    pulse(1, 0);
    checks++; if ({wr_bank_free, rd_frame_valid} !== 2'b11) begin errors++; $display("FAIL one_frame got %b want 11", {wr_bank_free, rd_frame_valid}); end
  endtask

  task automatic test_async_reset();
    write_px(4, 4, 8'h99, 1);
    pulse(0, 1);
    read_px(4, 4);
    checks++; if (rd_q !== 8'h99) begin errors++; $display("FAIL pre_reset_read got %h want 99", rd_q); end
    wr_waddrX = 9'd6; wr_waddrY = 8'd6; wr_wdata = 8'h42; wr_we = 1;
    #3 resetn = 0;
    #1;
    checks++; if ({rd_q, rd_frame_valid, err_overflow, err_addr} !== 11'h000) begin errors++; $display("FAIL async_outputs got %h want 000", {rd_q, rd_frame_valid, err_overflow, err_addr}); end
    checks++; if (wr_bank_free !== 1'b1) begin errors++; $display("FAIL async_free got %b want 1", wr_bank_free); end
    wr_we = 0;
    model_reset();
    @(posedge clk); #1;
    resetn = 1;
    pulse(0, 1);
    checks++; if (rd_frame_valid !== 1'b0) begin errors++; $display("FAIL post_reset_valid got %b want 0", rd_frame_valid); end
    read_px(4, 4);
    checks++; if (rd_q !== 8'h00) begin errors++; $display("FAIL post_reset_read got %h want 00", rd_q); end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_frame_write();
    test_overflow();
    test_back_to_back();
    test_addr_range();
    test_release_empty();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
